xbar_output_arbiter: RTL and testbench

- Per-output-port wormhole arbiter for the 5-input router crossbar.
- Shares one output port between the N, E, W, S and L input FIFOs using round-robin priority.
- Drives the crossbar's one-hot select lines for that output, and the read-enable of the winning input FIFO.
- Holds the grant from the head flit until the tail flit of the packet has been forwarded.
- One instance per output port.

---
 rtl/xbar_output_arbiter.sv | 92 +++++++++
 tb/tb_xbar_output_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/xbar_output_arbiter.sv
// rtl/xbar_output_arbiter.sv - round-robin wormhole arbiter for one crossbar output port
module xbar_output_arbiter #(
    parameter int PORTS     = 5,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PORTS-1:0]     req,
    input  logic [PORTS-1:0]     tail,
    input  logic                 out_ready,
    output logic [PORTS-1:0]     sel_out,
    output logic [PORTS-1:0]     rd_en,
    output logic                 valid_out,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] pkt_cnt
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]       state;
    logic [2:0]       last;
    logic [2:0]       owner_idx;
    logic [PORTS-1:0] grant_vec;
    logic             found;
    logic             owner_req;
    logic             owner_tail;
    logic             transfer;
    int               cand;

    // Scan upward from the port after the previous winner so every port gets a turn.
    always_comb begin
        grant_vec = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 1; k <= PORTS; k++) begin
            cand = (int'(last) + k) % PORTS;
            if (!found && req[cand]) begin
                grant_vec[cand] = 1'b1;
                found           = 1'b1;
            end
        end
    end

    always_comb begin
        owner_idx = 3'd0;
        for (int i = 0; i < PORTS; i++) begin
            if (sel_out[i]) begin
                owner_idx = 3'(i);
            end
        end
    end

    assign owner_req  = |(sel_out & req);
    assign owner_tail = |(sel_out & tail);
    assign transfer   = (state == LOCKED) && owner_req && out_ready;
    assign rd_en      = transfer ? sel_out : '0;
    assign valid_out  = transfer;
    assign busy       = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sel_out <= '0;
            last    <= 3'(PORTS - 1);
            pkt_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        sel_out <= grant_vec;
                        state   <= LOCKED;
                    end
                end
                LOCKED: begin
                    // Other requesters and non-owner tails are ignored until the owner's tail leaves.
                    if (transfer && owner_tail) begin
                        state   <= IDLE;
                        sel_out <= '0;
                        last    <= owner_idx;
                        pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    sel_out <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xbar_output_arbiter.sv
// tb/tb_xbar_output_arbiter.sv - directed self-checking bench for xbar_output_arbiter
module tb_xbar_output_arbiter;

    logic        clk;
    logic        rst;
    logic [4:0]  req;
    logic [4:0]  tail;
    logic        out_ready;
    logic [4:0]  sel_out;
    logic [4:0]  rd_en;
    logic        valid_out;
    logic        busy;
    logic [15:0] pkt_cnt;
    logic [4:0]  sel_out_s;
    logic [4:0]  rd_en_s;
    logic        valid_out_s;
    logic        busy_s;
    logic [3:0]  pkt_cnt_s;

    int tests_run;
    int tests_failed;
    int grant_count [5];

    xbar_output_arbiter #(.PORTS(5), .CNT_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .tail      (tail),
        .out_ready (out_ready),
        .sel_out   (sel_out),
        .rd_en     (rd_en),
        .valid_out (valid_out),
        .busy      (busy),
        .pkt_cnt   (pkt_cnt)
    );

    xbar_output_arbiter #(.PORTS(5), .CNT_WIDTH(4)) dut_small (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .tail      (tail),
        .out_ready (out_ready),
        .sel_out   (sel_out_s),
        .rd_en     (rd_en_s),
        .valid_out (valid_out_s),
        .busy      (busy_s),
        .pkt_cnt   (pkt_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < 5; i++) grant_count[i] = 0;
        rst       = 1'b1;
        req       = 5'b00000;
        tail      = 5'b00000;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_sel",   32'(sel_out),   32'h0);
        check("rst_rd_en", 32'(rd_en),     32'h0);
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_busy",  32'(busy),      32'h0);
        check("rst_cnt",   32'(pkt_cnt),   32'h0);

        // N and L request, single-flit packets
        req = 5'b10001; tail = 5'b11111; out_ready = 1'b1;
        step();
        check("t1_c1_sel",   32'(sel_out),   32'h01);
        check("t1_c1_busy",  32'(busy),      32'h1);
        check("t1_c2_rd_en", 32'(rd_en),     32'h01);
        check("t1_c2_valid", 32'(valid_out), 32'h1);
        step();
        check("t1_c3_sel",  32'(sel_out), 32'h00);
        check("t1_c3_busy", 32'(busy),    32'h0);
        check("t1_c3_cnt",  32'(pkt_cnt), 32'd1);
        step();
        check("t1_c4_sel",   32'(sel_out), 32'h10);
        check("t1_c4_rd_en", 32'(rd_en),   32'h10);
        step();
        req = 5'b00000;
        #1;
        check("t1_cnt", 32'(pkt_cnt), 32'd2);
        step();

        // all five requesting single-flit packets: strict rotation from N
        req = 5'b11111; tail = 5'b11111;
        for (int p = 0; p < 25; p++) begin
            step();
            check("t2_sel",   32'(sel_out), 32'(5'b00001 << (p % 5)));
            check("t2_rd_en", 32'(rd_en),   32'(5'b00001 << (p % 5)));
            for (int i = 0; i < 5; i++) if (sel_out[i]) grant_count[i]++;
            step();
        end
        for (int i = 0; i < 5; i++) check("t2_share", 32'(grant_count[i]), 32'd5);
        check("t2_cnt", 32'(pkt_cnt), 32'd27);
        req = 5'b00000;
        step();

        // E 4-flit packet with W waiting; W's tail bit must not end E's packet
        req = 5'b00110; tail = 5'b00100;
        step();
        for (int f = 1; f <= 4; f++) begin
            tail = (f == 4) ? 5'b00010 : 5'b00100;
            #1;
            check("t3_sel",   32'(sel_out), 32'h02);
            check("t3_rd_en", 32'(rd_en),   32'h02);
            step();
        end
        req = 5'b00100;
        #1;
        check("t3_bubble_sel",  32'(sel_out), 32'h00);
        check("t3_bubble_busy", 32'(busy),    32'h0);
        step();
        check("t3_w_sel", 32'(sel_out), 32'h04);
        tail = 5'b00100;
        step();
        req = 5'b00000;
        #1;
        check("t3_cnt", 32'(pkt_cnt), 32'd29);

        // N owner drops req for 3 cycles while others request
        req = 5'b00001; tail = 5'b00000;
        step();
        check("t4_sel", 32'(sel_out), 32'h01);
        check("t4_flit1_rd_en", 32'(rd_en), 32'h01);
        step();
        req = 5'b11110;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t4_hold_sel",   32'(sel_out),   32'h01);
            check("t4_hold_rd_en", 32'(rd_en),     32'h00);
            check("t4_hold_valid", 32'(valid_out), 32'h0);
            check("t4_hold_busy",  32'(busy),      32'h1);
            step();
        end
        req = 5'b00001; tail = 5'b00001;
        #1;
        check("t4_resume_rd_en", 32'(rd_en), 32'h01);
        step();
        req = 5'b00000;
        #1;
        check("t4_cnt", 32'(pkt_cnt), 32'd30);
        check("t4_idle_sel", 32'(sel_out), 32'h00);

        // S locked with out_ready low for 5 cycles
        req = 5'b01000; tail = 5'b01000; out_ready = 1'b0;
        step();
        for (int c = 0; c < 5; c++) begin
            check("t5_stall_sel",   32'(sel_out),   32'h08);
            check("t5_stall_rd_en", 32'(rd_en),     32'h00);
            check("t5_stall_valid", 32'(valid_out), 32'h0);
            check("t5_stall_cnt",   32'(pkt_cnt),   32'd30);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("t5_fire_rd_en", 32'(rd_en),     32'h08);
        check("t5_fire_valid", 32'(valid_out), 32'h1);
        step();
        req = 5'b00000;
        #1;
        check("t5_cnt", 32'(pkt_cnt), 32'd31);

        // reset while L is mid-packet
        req = 5'b10000; tail = 5'b00000;
        step();
        check("t6_sel", 32'(sel_out), 32'h10);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("t6_rst_sel",  32'(sel_out), 32'h00);
        check("t6_rst_busy", 32'(busy),    32'h0);
        check("t6_rst_cnt",  32'(pkt_cnt), 32'd0);
        req = 5'b11111; tail = 5'b11111;
        step();
        check("t6_first_n", 32'(sel_out), 32'h01);
        step();
        req = 5'b00000;
        rst = 1'b1;
        step();
        rst = 1'b0;

        // 17 single-flit packets: 4-bit counter wraps to 1
        req = 5'b00001; tail = 5'b00001;
        for (int p = 0; p < 17; p++) begin
            step();
            step();
        end
        req = 5'b00000;
        #1;
        check("t7_wrap_cnt4", 32'(pkt_cnt_s), 32'd1);
        check("t7_cnt16",     32'(pkt_cnt),   32'd17);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
